regfile_move_engine: RTL and testbench

// - Parametrised register file with a handshaked operation engine: load, move, swap and clear.
// - Generalises the fixed 8 x 16-bit source/destination move datapath in width, depth and operation set.
// - Sits between the control unit, which issues ops, and the datapath, which reads src_data.
// - Multi-cycle ops (SWAP) are sequenced by an internal FSM; completion is reported with a done pulse.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_array.sv | 57 +++++
 rtl/regfile_move_engine.sv | 118 +++++++++++
 tb/tb_regfile_move_engine.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the register-file move engine.
//   op_e    - operation encoding on the op port (5-7 are illegal and reported via err)
//   state_e - engine FSM states
package regfile_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_MOVE  = 3'd2,
      OP_SWAP  = 3'd3,
      OP_CLEAR = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EXEC    = 3'd1,
      SWAP_RD = 3'd2,
      SWAP_WR = 3'd3,
      DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/regfile_array.sv
// regfile_array: DEPTH x WIDTH register storage, async active-high reset.
//   clk, rst          clock / async reset (all registers cleared)
//   we0, wa0, wd0     write port 0
//   we1, wa1, wd1     write port 1 (wins over port 0 on the same index)
//   ra0..ra2/rd0..rd2 combinational read ports
// Indices >= DEPTH read 0 and are never written. With HARDWIRE_R0 set,
// register 0 reads 0 and ignores writes.
module regfile_array #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 8,
   parameter int HARDWIRE_R0 = 0,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we0,
   input  logic [AW-1:0]    wa0,
   input  logic [WIDTH-1:0] wd0,
   input  logic             we1,
   input  logic [AW-1:0]    wa1,
   input  logic [WIDTH-1:0] wd1,
   input  logic [AW-1:0]    ra0,
   output logic [WIDTH-1:0] rd0,
   input  logic [AW-1:0]    ra1,
   output logic [WIDTH-1:0] rd1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd2
);

   logic [DEPTH-1:0][WIDTH-1:0] regs;

   function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
      if (32'(a) >= DEPTH || (HARDWIRE_R0 != 0 && a == '0))
         return '0;
      return regs[a];
   endfunction

   assign rd0 = rd(ra0);
   assign rd1 = rd(ra1);
   assign rd2 = rd(ra2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!(HARDWIRE_R0 != 0 && i == 0)) begin
               if (we1 && wa1 == AW'(i))
                  regs[i] <= wd1;
               else if (we0 && wa0 == AW'(i))
                  regs[i] <= wd0;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_move_engine.sv
// regfile_move_engine: register file with a handshaked op engine
// (NOP/LOAD/MOVE/SWAP/CLEAR).
//   clk, rst      clock / async active-high reset
//   op_valid      request; accepted when op_ready is high at a rising edge
//   op_ready      high only while IDLE
//   op            operation code (5-7 illegal)
//   source        source index (MOVE/SWAP) and live read index for src_data
//   destination   destination index
//   data_in       LOAD data
//   src_data      combinational read of regs[source]
//   done          one-cycle completion pulse
//   err           pulses with done for an illegal op
module regfile_move_engine
   import regfile_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 8,
   parameter int HARDWIRE_R0 = 0,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    source,
   input  logic [AW-1:0]    destination,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] src_data,
   output logic             done,
   output logic             err
);

   state_e           state;
   logic [2:0]       l_op;
   logic [AW-1:0]    l_src, l_dst;
   logic [WIDTH-1:0] l_data, temp;
   logic [WIDTH-1:0] rd_src, rd_dst;

   logic             we0, we1;
   logic [AW-1:0]    wa0, wa1;
   logic [WIDTH-1:0] wd0, wd1;

   assign op_ready = (state == IDLE);
   assign done     = (state == DONE);
   assign err      = done && (l_op > 3'd4);

   // Port 0 serves EXEC writes and the src half of SWAP; port 1 the dst half.
   always_comb begin
      we0 = 1'b0;
      wa0 = l_dst;
      wd0 = '0;
      we1 = 1'b0;
      wa1 = l_dst;
      wd1 = temp;
      case (state)
         EXEC: begin
            case (l_op)
               OP_LOAD:  begin we0 = 1'b1; wd0 = l_data; end
               OP_MOVE:  begin we0 = 1'b1; wd0 = rd_src; end
               OP_CLEAR: begin we0 = 1'b1; wd0 = '0;     end
               default:  ;
            endcase
         end
         SWAP_RD: begin
            we0 = 1'b1;
            wa0 = l_src;
            wd0 = rd_dst;
         end
         SWAP_WR: we1 = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         l_op   <= '0;
         l_src  <= '0;
         l_dst  <= '0;
         l_data <= '0;
         temp   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op_valid) begin
                  l_op   <= op;
                  l_src  <= source;
                  l_dst  <= destination;
                  l_data <= data_in;
                  state  <= (op == OP_SWAP) ? SWAP_RD : EXEC;
               end
            end
            EXEC:    state <= DONE;
            SWAP_RD: begin
               // Capture old src before it is overwritten on this same edge.
               temp  <= rd_src;
               state <= SWAP_WR;
            end
            SWAP_WR: state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   regfile_array #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .HARDWIRE_R0(HARDWIRE_R0)
   ) u_array (
      .clk(clk), .rst(rst),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra0(source), .rd0(src_data),
      .ra1(l_src),  .rd1(rd_src),
      .ra2(l_dst),  .rd2(rd_dst)
   );

endmodule

// File: tb/tb_regfile_move_engine.sv
// tb_regfile_move_engine: drives two engines (HARDWIRE_R0=0 and =1) with the
// same op stream and checks both against a per-op reference model.
module tb_regfile_move_engine;

   typedef logic [7:0][15:0] rf_t;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  src;
      logic [2:0]  dst;
      logic [15:0] data;
      logic [2:0]  ci;
      logic [15:0] e0;
      logic [15:0] e1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op, source, destination;
   logic [15:0] data_in;
   logic        ready_a, done_a, err_a, ready_b, done_b, err_b;
   logic [15:0] sd_a, sd_b;

   rf_t m0, m1;
   int  checks = 0;
   int  errors = 0;
   vec_t tbl[13];

   always #5 clk = ~clk;

   regfile_move_engine #(.WIDTH(16), .DEPTH(8), .HARDWIRE_R0(0)) dut_a (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(ready_a), .op(op),
      .source(source), .destination(destination), .data_in(data_in),
      .src_data(sd_a), .done(done_a), .err(err_a));

   regfile_move_engine #(.WIDTH(16), .DEPTH(8), .HARDWIRE_R0(1)) dut_b (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(ready_b), .op(op),
      .source(source), .destination(destination), .data_in(data_in),
      .src_data(sd_b), .done(done_b), .err(err_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference semantics of one op on a register file.
   function automatic rf_t apply(input rf_t m, input bit hw0, input logic [2:0] o,
                                 input logic [2:0] s, input logic [2:0] d,
                                 input logic [15:0] x);
      rf_t r = m;
      logic [15:0] vs, vd;
      vs = (hw0 && s == 0) ? 16'h0 : m[s];
      vd = (hw0 && d == 0) ? 16'h0 : m[d];
      case (o)
         3'd1: r[d] = x;
         3'd2: r[d] = vs;
         3'd3: begin r[s] = vd; r[d] = vs; end
         3'd4: r[d] = 16'h0;
         default: ;
      endcase
      if (hw0) r[0] = 16'h0;
      return r;
   endfunction

   task automatic sweep(input string tag);
      for (int i = 0; i < 8; i++) begin
         source = 3'(i);
         #1;
         chk({tag, "_a"}, {16'h0, sd_a}, {16'h0, m0[i]});
         chk({tag, "_b"}, {16'h0, sd_b}, {16'h0, m1[i]});
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [2:0] s,
                        input logic [2:0] d, input logic [15:0] x);
      rf_t n0, n1;
      int  lat, w;
      @(negedge clk);
      w = 0;
      while (!ready_a && w < 20) begin @(negedge clk); w++; end
      chk("ready_before", {31'h0, ready_a}, 32'd1);
      op_valid = 1'b1; op = o; source = s; destination = d; data_in = x;
      n0  = apply(m0, 1'b0, o, s, d, x);
      n1  = apply(m1, 1'b1, o, s, d, x);
      lat = (o == 3'd3) ? 2 : 1;
      @(posedge clk); #1;
      // Scramble inputs after accept; watch the destination on the live read.
      op_valid = 1'b0; op = 3'($urandom); source = d;
      destination = 3'($urandom); data_in = 16'($urandom);
      @(negedge clk);
      chk("busy_ready_a", {31'h0, ready_a}, 32'd0);
      chk("busy_done_a", {31'h0, done_a}, 32'd0);
      chk("busy_done_b", {31'h0, done_b}, 32'd0);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); @(negedge clk);
         chk("done_a", {31'h0, done_a}, {31'h0, k == lat});
         chk("done_b", {31'h0, done_b}, {31'h0, k == lat});
         chk("err_a", {31'h0, err_a}, {31'h0, k == lat && o > 3'd4});
         chk("err_b", {31'h0, err_b}, {31'h0, k == lat && o > 3'd4});
         chk("ready_b_busy", {31'h0, ready_b}, 32'd0);
         if (k == lat) begin
            chk("wr_vis_a", {16'h0, sd_a}, {16'h0, n0[d]});
            chk("wr_vis_b", {16'h0, sd_b}, {16'h0, n1[d]});
         end
      end
      @(posedge clk); @(negedge clk);
      chk("ready_after_a", {31'h0, ready_a}, 32'd1);
      chk("ready_after_b", {31'h0, ready_b}, 32'd1);
      chk("done_after", {31'h0, done_a | done_b}, 32'd0);
      m0 = n0;
      m1 = n1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; op_valid = 1'b0; op = 3'd0; source = 3'd0;
      destination = 3'd0; data_in = 16'h0;
      m0 = '0; m1 = '0;

      //            op    src   dst   data      ci    e0        e1
      tbl[0]  = '{3'd1, 3'd0, 3'd3, 16'h000F, 3'd3, 16'h000F, 16'h000F};
      tbl[1]  = '{3'd2, 3'd3, 3'd5, 16'h0000, 3'd5, 16'h000F, 16'h000F};
      tbl[2]  = '{3'd1, 3'd0, 3'd1, 16'hAAAA, 3'd1, 16'hAAAA, 16'hAAAA};
      tbl[3]  = '{3'd1, 3'd0, 3'd2, 16'h5555, 3'd2, 16'h5555, 16'h5555};
      tbl[4]  = '{3'd3, 3'd1, 3'd2, 16'h0000, 3'd1, 16'h5555, 16'h5555};
      tbl[5]  = '{3'd0, 3'd0, 3'd0, 16'h0000, 3'd2, 16'hAAAA, 16'hAAAA};
      tbl[6]  = '{3'd1, 3'd0, 3'd0, 16'hFFFF, 3'd0, 16'hFFFF, 16'h0000};
      tbl[7]  = '{3'd7, 3'd3, 3'd3, 16'h1234, 3'd3, 16'h000F, 16'h000F};
      tbl[8]  = '{3'd3, 3'd0, 3'd5, 16'h0000, 3'd5, 16'hFFFF, 16'h0000};
      tbl[9]  = '{3'd0, 3'd0, 3'd0, 16'h0000, 3'd0, 16'h000F, 16'h0000};
      tbl[10] = '{3'd3, 3'd3, 3'd3, 16'h0000, 3'd3, 16'h000F, 16'h000F};
      tbl[11] = '{3'd4, 3'd0, 3'd3, 16'h0000, 3'd3, 16'h0000, 16'h0000};
      tbl[12] = '{3'd2, 3'd5, 3'd5, 16'h0000, 3'd5, 16'hFFFF, 16'h0000};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", {30'h0, ready_a, ready_b}, 32'd3);
      chk("rst_done", {30'h0, done_a, done_b}, 32'd0);
      chk("rst_err", {30'h0, err_a, err_b}, 32'd0);
      sweep("rst_rd");

      // Directed table
      foreach (tbl[i]) begin
         issue(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].data);
         source = tbl[i].ci;
         #1;
         chk("tbl_a", {16'h0, sd_a}, {16'h0, tbl[i].e0});
         chk("tbl_b", {16'h0, sd_b}, {16'h0, tbl[i].e1});
         sweep("tbl_rd");
      end

      // Back-to-back: second request held during EXEC waits for IDLE
      @(negedge clk);
      op_valid = 1'b1; op = 3'd2; source = 3'd1; destination = 3'd6;
      @(posedge clk); #1;
      op = 3'd1; destination = 3'd6; data_in = 16'h1234; source = 3'd6;
      @(negedge clk);
      chk("b2b_busy", {31'h0, ready_a}, 32'd0);
      chk("b2b_r6_old", {16'h0, sd_a}, {16'h0, m0[6]});
      @(negedge clk);
      chk("b2b_done1", {31'h0, done_a}, 32'd1);
      chk("b2b_mv", {16'h0, sd_a}, {16'h0, m0[1]});
      chk("b2b_mv_b", {16'h0, sd_b}, {16'h0, m1[1]});
      @(negedge clk);
      chk("b2b_idle", {31'h0, ready_a}, 32'd1);
      chk("b2b_nodone", {31'h0, done_a}, 32'd0);
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      chk("b2b_busy2", {31'h0, ready_a}, 32'd0);
      chk("b2b_r6_mid", {16'h0, sd_a}, {16'h0, m0[1]});
      @(negedge clk);
      chk("b2b_done2", {31'h0, done_a}, 32'd1);
      chk("b2b_ld", {16'h0, sd_a}, 32'h1234);
      chk("b2b_ld_b", {16'h0, sd_b}, 32'h1234);
      m0[6] = 16'h1234; m1[6] = 16'h1234;
      @(negedge clk);
      sweep("b2b_rd");

      // Random ops against the model
      for (int n = 0; n < 60; n++) begin
         issue(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 16'($urandom));
         sweep("rnd_rd");
      end

      // Reset in the middle of a SWAP
      issue(3'd1, 3'd0, 3'd1, 16'hAAAA);
      issue(3'd1, 3'd0, 3'd2, 16'h5555);
      @(negedge clk);
      op_valid = 1'b1; op = 3'd3; source = 3'd1; destination = 3'd2;
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_half", {16'h0, sd_a}, 32'h5555);
      rst = 1'b1;
      #1;
      m0 = '0; m1 = '0;
      chk("abort_ready", {30'h0, ready_a, ready_b}, 32'd3);
      chk("abort_done", {30'h0, done_a, done_b}, 32'd0);
      sweep("abort_rd");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_nodone", {30'h0, done_a, done_b}, 32'd0);
      end
      sweep("post_abort_rd");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
